// File: rtl/gobang_sound_pkg.sv
// Shared types and constants for the sound sequencer: FSM states, ROM word layout, clip length.
package gobang_sound_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_FIN
  } state_t;

  localparam int PERIOD_MSB = 15;
  localparam int PERIOD_LSB = 8;
  localparam int DUR_MSB    = 7;
  localparam int DUR_LSB    = 0;
  localparam int CLIP_LEN   = 16;

  // A zero duration on a sounding note still plays one tick.
  function automatic logic [7:0] eff_dur(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles tone every period*PERIOD_UNIT cycles while enabled; period 0 is a rest.
module tone_gen #(
  parameter int PERIOD_UNIT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] period,
  output logic       tone
);
  localparam int HPW = 8 + $clog2(PERIOD_UNIT);

  logic [HPW-1:0] hp_cnt;
  logic [HPW-1:0] hp_last;

  assign hp_last = HPW'(period) * HPW'(PERIOD_UNIT) - HPW'(1);

  // Dropping en forces tone low at the same edge, so a note never ends high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hp_cnt <= '0;
      tone   <= 1'b0;
    end else if (!en || period == 8'd0) begin
      hp_cnt <= '0;
      tone   <= 1'b0;
    end else if (hp_cnt == hp_last) begin
      hp_cnt <= '0;
      tone   <= ~tone;
    end else begin
      hp_cnt <= hp_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sound_player.sv
// Clip sequencer: walks up to 16 ROM words of a clip and plays each as a square-wave note.
// Optional feature macro SOUND_PLAYER_LOOP_EN adds a 'loop' input that restarts the clip at its end.
module sound_player
  import gobang_sound_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int PERIOD_UNIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  clip_sel,
  input  logic        stop,
`ifdef SOUND_PLAYER_LOOP_EN
  input  logic        loop,
`endif
  output logic [5:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        busy,
  output logic        done,
  output logic        tone
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        state, state_n;
  logic [1:0]    clip_q;
  logic [3:0]    step;
  logic [7:0]    period, dur, dur_cnt;
  logic [TW-1:0] tick_cnt;
  logic          tick_last, note_end, clip_end, loop_on, playing;

`ifdef SOUND_PLAYER_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  always_comb begin
    tick_last = (tick_cnt == TW'(TICK_DIV - 1));
    note_end  = (state == S_PLAY) && tick_last && (dur_cnt == dur - 8'd1);
    clip_end  = ((state == S_LOAD) && (rom_data == 16'h0000)) ||
                (note_end && (step == 4'(CLIP_LEN - 1)));
    state_n   = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_FETCH;
      S_FETCH: state_n = S_LOAD;
      S_LOAD:  state_n = clip_end ? (loop_on ? S_FETCH : S_FIN) : S_PLAY;
      S_PLAY:  if (note_end) state_n = (clip_end && !loop_on) ? S_FIN : S_FETCH;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // FIN always drains to IDLE so done stays a single-cycle pulse.
    if (stop && state != S_IDLE && state != S_FIN) state_n = S_FIN;
    playing = (state == S_PLAY) && (state_n == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      clip_q   <= '0;
      step     <= '0;
      period   <= '0;
      dur      <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else begin
      state <= state_n;
      if (playing) begin
        tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
        if (tick_last) dur_cnt <= dur_cnt + 8'd1;
      end else begin
        tick_cnt <= '0;
        dur_cnt  <= '0;
      end
      if (state == S_IDLE && state_n == S_FETCH) begin
        clip_q <= clip_sel;
        step   <= '0;
      end else if (state_n == S_FETCH) begin
        step <= clip_end ? 4'd0 : step + 4'd1;
      end
      if (state == S_LOAD && state_n == S_PLAY) begin
        period <= rom_data[PERIOD_MSB:PERIOD_LSB];
        dur    <= eff_dur(rom_data[DUR_MSB:DUR_LSB]);
      end
    end
  end

  assign rom_addr = {clip_q, step};
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);

  tone_gen #(.PERIOD_UNIT(PERIOD_UNIT)) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (playing),
    .period (period),
    .tone   (tone)
  );

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: per-cycle expected traces built from clip contents, randomized clips, stop/reset aborts.
module tb_sound_player;
  localparam int TICK_DIV    = 10;
  localparam int PERIOD_UNIT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  clip_sel = 2'd0;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy, done, tone;
`ifdef SOUND_PLAYER_LOOP_EN
  logic        loop = 1'b0;
`endif

  logic [15:0] mem [64];
  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [5:0] addr;
    logic       busy;
    logic       done;
    logic       tone;
  } obs_t;

  obs_t exp_q[$];
  int   iter_idx[$];
  int   play_idx[16];

  sound_player #(.TICK_DIV(TICK_DIV), .PERIOD_UNIT(PERIOD_UNIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clip_sel (clip_sel),
    .stop     (stop),
`ifdef SOUND_PLAYER_LOOP_EN
    .loop     (loop),
`endif
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .tone     (tone)
  );

  always #5 clk = ~clk;

  // ROM with one cycle of registered latency.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input int addr, input bit b, input bit d, input bit t);
    obs_t o;
    o.addr = 6'(addr);
    o.busy = b;
    o.done = d;
    o.tone = t;
    return o;
  endfunction

  function automatic obs_t cur();
    return mk(int'(rom_addr), busy, done, tone);
  endfunction

  // Expected outputs for every cycle from the first FETCH to the IDLE after done.
  task automatic build(input int base, input int iters);
    logic [15:0] w;
    int p, d, n, hp, last;
    exp_q.delete();
    iter_idx.delete();
    last = base;
    for (int it = 0; it < iters; it++) begin
      iter_idx.push_back(exp_q.size());
      for (int s = 0; s < 16; s++) begin
        w = mem[base + s];
        last = base + s;
        exp_q.push_back(mk(last, 1, 0, 0));
        exp_q.push_back(mk(last, 1, 0, 0));
        if (w == 16'h0000) break;
        p  = int'(w[15:8]);
        d  = (w[7:0] == 8'd0) ? 1 : int'(w[7:0]);
        n  = d * TICK_DIV;
        hp = p * PERIOD_UNIT;
        if (it == 0) play_idx[s] = exp_q.size();
        for (int j = 0; j < n; j++)
          exp_q.push_back(mk(last, 1, 0, (p == 0) ? 1'b0 : 1'(((j / hp) % 2))));
      end
    end
    exp_q.push_back(mk(last, 1, 1, 0));
    exp_q.push_back(mk(last, 0, 0, 0));
  endtask

  task automatic run(input string name, input int clip, input int iters,
                     input int stop_at, input int start_at);
    obs_t keep;
    build(clip * 16, iters);
    @(negedge clk);
    clip_sel = 2'(clip);
    start = 1'b1;
`ifdef SOUND_PLAYER_LOOP_EN
    loop = (iters > 1);
`endif
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
      chk($sformatf("%s_c%0d", name, i), 32'(cur()), 32'(exp_q[i]));
      if (i == stop_at) begin
        stop = 1'b1;
        keep = exp_q[i];
        while (exp_q.size() > i + 1) void'(exp_q.pop_back());
        exp_q.push_back(mk(int'(keep.addr), 1, 1, 0));
        exp_q.push_back(mk(int'(keep.addr), 0, 0, 0));
      end
      if (i == start_at) begin
        start = 1'b1;
        clip_sel = ~2'(clip);
      end
`ifdef SOUND_PLAYER_LOOP_EN
      if (iters > 1 && i == iter_idx[iters - 1]) loop = 1'b0;
`endif
    end
    stop = 1'b0;
    start = 1'b0;
  endtask

  task automatic rand_clip(input int clip, input int marker);
    logic [15:0] w;
    for (int s = 0; s < 16; s++) begin
      w = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 3))};
      if (w == 16'h0000) w = 16'h0101;
      mem[clip * 16 + s] = w;
    end
    if (marker >= 0) mem[clip * 16 + marker] = 16'h0000;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
    mem[16] = 16'h0305;
    mem[17] = 16'h0000;
    mem[32] = 16'h0003;
    mem[33] = 16'h0201;
    mem[34] = 16'h0000;
    rand_clip(0, -1);

    repeat (3) @(negedge clk);
    chk("reset_state", 32'(cur()), 32'(mk(0, 0, 0, 0)));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(cur()), 32'(mk(0, 0, 0, 0)));

    run("clip1_basic", 1, 1, -1, -1);
    run("rest_note", 2, 1, -1, -1);
    run("clip0_walk16", 0, 1, -1, -1);

    // Stop in the middle of note 2, with an ignored start during note 1.
    build(0, 1);
    run("stop_mid", 0, 1, play_idx[1] + 3, play_idx[0] + 1);

    // Reset in the middle of a note aborts with no done pulse.
    build(0, 1);
    @(negedge clk);
    clip_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (play_idx[0] + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_note", 32'(cur()), 32'(mk(0, 0, 0, 0)));
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_quiet", 32'(cur()), 32'(mk(0, 0, 0, 0)));
    end
    run("after_rst", 1, 1, -1, -1);

    for (int k = 0; k < 4; k++) begin
      rand_clip(2 + (k % 2), int'($urandom_range(1, 15)));
      run($sformatf("rand%0d", k), 2 + (k % 2), 1, -1, -1);
    end
    rand_clip(1, -1);
    run("rand_full", 1, 1, int'($urandom_range(5, 200)), -1);

`ifdef SOUND_PLAYER_LOOP_EN
    mem[48] = 16'h0102;
    mem[49] = 16'h0201;
    mem[50] = 16'h0000;
    run("loop3", 3, 3, -1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sound_player.md
# sound_player

Sequencer that plays a short sound clip by walking 16 consecutive words of the 64×16 sound ROM and turning each word into a square-wave note on a single audio pin. It sits directly upstream of the ROM: it drives the ROM address and consumes the ROM data one cycle later. Game logic triggers clips, for example on a stone placement or a win. The tone output goes to the board's PWM audio pin.

## Interface
- `TICK_DIV`, default 100000: clock cycles per duration tick (1 ms at 100 MHz).
- `PERIOD_UNIT`, default 64: clock cycles per unit of the half-period code.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to play the clip selected by `clip_sel`.
- `clip_sel`  in  2  clip index; clip base address = `{clip_sel, 4'h0}`.
- `stop`  in  1  abort playback.
- `rom_addr`  out  6  address to the ROM; the ROM registers it internally.
- `rom_data`  in  16  ROM word; `[15:8]` = half-period code, `[7:0]` = duration in ticks.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at clip end or abort.
- `tone`  out  1  square-wave audio output.

## Operation
- States:
  - IDLE.
  - FETCH: `rom_addr` is stable and the ROM captures it at the end of the cycle.
  - LOAD: `rom_data` is valid and is latched.
  - PLAY.
  - FIN.
- IDLE → FETCH on `start`:
  - `step` ← 0.
  - `rom_addr` ← `{clip_sel, 4'h0}`.
  - `clip_sel` is sampled only at this point.
- FETCH → LOAD unconditionally, after 1 cycle.
- LOAD behaviour:
  - If `rom_data == 16'h0000`, go to FIN (end-of-clip marker).
  - Otherwise latch `period = rom_data[15:8]` and `dur = rom_data[7:0]`, then go to PLAY.
- PLAY, tone generation:
  - Half-period counter counts `period*PERIOD_UNIT` cycles, then toggles `tone`.
  - `period == 0` is a rest: `tone` is held 0.
- PLAY, duration:
  - Tick counter counts `TICK_DIV` cycles per tick.
  - After `dur` ticks, `tone` ← 0.
  - If `step == 15`, go to FIN; otherwise `step` + 1, `rom_addr` + 1, go to FETCH.
  - `dur == 0` with a nonzero `period` plays exactly 1 tick (treated as 1).
- FIN: `done` = 1 for one cycle, `busy` = 0 from the next cycle, then IDLE.
- `stop` in any state except IDLE: next state is FIN and `tone` ← 0. `stop` takes priority over all other transitions.
- `start` outside IDLE is ignored. In FIN, `start` is also ignored; it is not queued.
- `rom_addr` wraps within the clip only: the low 4 bits are `step` and the upper 2 bits are held.

## Timing
- Reset values (`rst_n` low at a rising edge):
  - state IDLE.
  - `rom_addr` = 0, `busy` = 0, `done` = 0, `tone` = 0.
  - all counters 0.
- Reset mid-playback aborts immediately. No `done` pulse is produced.
- `busy` rises the cycle after `start` is sampled.
- Latency from `start` to the first `tone` toggle: 3 + `period*PERIOD_UNIT` cycles.
- Note-to-note gap: 2 cycles (FETCH + LOAD), during which `tone` = 0.
- `done` is asserted exactly 1 cycle after the terminating condition (end marker, step 15 complete, or `stop`).
- Counter widths:
  - half-period counter: 8 + clog2(`PERIOD_UNIT`) bits.
  - tick counter: clog2(`TICK_DIV`) bits.
  - duration counter: 8 bits.
  - No counter may overflow at `period = 255` or `dur = 255`.

## Configuration
- `SOUND_PLAYER_LOOP_EN` defined:
  - Adds input `loop` (1 bit).
  - At clip end (end marker or step 15) with `loop` = 1: `step` ← 0, `rom_addr` ← clip base, go to FETCH, no `done`.
  - `stop` still aborts.
- Not defined: no `loop` port, and every clip plays once.

## Structure
- Shared package `gobang_sound_pkg` holds:
  - the state enum (IDLE, FETCH, LOAD, PLAY, FIN).
  - the word field positions (`PERIOD_MSB/LSB`, `DUR_MSB/LSB`).
  - the constant `CLIP_LEN = 16`.
- One sub-module: `tone_gen`, which holds the half-period counter and toggle. It takes `en` and `period` and outputs `tone`.
- Tick and duration counting stay in `sound_player`.

## Test plan
- Use `TICK_DIV=10`, `PERIOD_UNIT=2`, with a behavioural ROM model that has 1-cycle registered latency.
- Clip 1 is `{16'h0305, 16'h0000}`; `start` with `clip_sel=1`:
  - `rom_addr` reads 16, then 17.
  - `tone` toggles every 6 cycles for 50 cycles.
  - `done` pulses once; `busy` is high throughout.
- Clip with word `16'h0003`: `tone` stays 0 for 30 cycles, then playback proceeds to the next word.
- Clip 0 has all 16 words nonzero:
  - `rom_addr` walks 0..15 and never reaches 16.
  - `done` follows the 16th note.
- `stop` asserted mid-PLAY on note 2:
  - `tone` is 0 next cycle.
  - `done` pulses 1 cycle after `stop`.
  - A `start` issued while `busy` is ignored, and `rom_addr` is unchanged.
- `rst_n` low mid-note: all outputs are 0 next cycle with no `done`. A `start` after release plays normally.
- With `SOUND_PLAYER_LOOP_EN` and `loop=1`:
  - A two-note clip repeats, with `rom_addr` returning to its base.
  - Dropping `loop` ends the clip at the next end with `done`.
